// File: rtl/musa_route_pkg.sv
// musa_route_pkg -- shared definitions for the demux_route family.
//   NCH            : number of destination channels (one-hot strobe width)
//   CODE_0000..1000: legal destination codes carried on in_ctrl
//   state_t        : router FSM states (IDLE, HOLD)
package musa_route_pkg;

  localparam int NCH = 6;

  localparam logic [3:0] CODE_0000 = 4'b0000;
  localparam logic [3:0] CODE_0001 = 4'b0001;
  localparam logic [3:0] CODE_0010 = 4'b0010;
  localparam logic [3:0] CODE_0011 = 4'b0011;
  localparam logic [3:0] CODE_0100 = 4'b0100;
  localparam logic [3:0] CODE_1000 = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/route_code_dec.sv
// route_code_dec -- combinational destination-code decoder.
// Ports:
//   ctrl   (in,  4)   : destination code
//   onehot (out, NCH) : one-hot channel select, all zero for an illegal code
//   legal  (out, 1)   : ctrl is one of the six legal codes
module route_code_dec
  import musa_route_pkg::*;
(
  input  logic [3:0]     ctrl,
  output logic [NCH-1:0] onehot,
  output logic           legal
);

  always_comb begin
    onehot = '0;
    legal  = 1'b1;
    case (ctrl)
      CODE_0000: onehot = 6'b000001;
      CODE_0001: onehot = 6'b000010;
      CODE_0010: onehot = 6'b000100;
      CODE_0011: onehot = 6'b001000;
      CODE_0100: onehot = 6'b010000;
      CODE_1000: onehot = 6'b100000;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/demux_route_18.sv
// demux_route_18 -- single-word holding demultiplexer with ack and timeout.
// A word offered in IDLE with a legal code is registered and strobed on the
// matching out_valid bit until that destination acks or the hold times out.
// Illegal codes are dropped with a one-cycle err_pulse.
// Optional feature: define DEMUX_ROUTE_ERRCNT_EN to add the saturating
// 8-bit err_count output.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_data/in_ctrl  : word and destination code, qualified by in_valid
//   in_ready         : high in IDLE and not in reset
//   out_data         : held word (shared by all destinations)
//   out_valid        : one-hot destination strobe
//   out_ack          : per-destination acceptance
//   err_pulse        : one-cycle flag for illegal code or timeout
//   err_count        : (optional) saturating error count
module demux_route_18
  import musa_route_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_ctrl,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ack,
  output logic              err_pulse
`ifdef DEMUX_ROUTE_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_p1;
  logic [NCH-1:0]    vld_p1, vld_nxt;
  logic              err_p1, err_nxt;
  logic [CW-1:0]     cnt_p1, cnt_nxt;
  logic [CW:0]       cnt_inc;
  logic              load, acked, expire;
  logic [NCH-1:0]    dec_onehot;
  logic              dec_legal;

  route_code_dec u_dec (
    .ctrl   (in_ctrl),
    .onehot (dec_onehot),
    .legal  (dec_legal)
  );

  assign in_ready = (state == IDLE) && !rst;
  // Only the ack bit of the selected destination can release the word.
  assign acked    = |(vld_p1 & out_ack);
  assign cnt_inc  = {1'b0, cnt_p1} + (CW+1)'(1);
  // Expiry fires on the edge where the hold-cycle count would reach TIMEOUT.
  assign expire   = (TIMEOUT != 0) && (cnt_inc == (CW+1)'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    vld_nxt   = vld_p1;
    cnt_nxt   = cnt_p1;
    err_nxt   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in_valid) begin
          if (dec_legal) begin
            load      = 1'b1;
            vld_nxt   = dec_onehot;
            state_nxt = HOLD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (acked) begin
          vld_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (expire) begin
          vld_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc[CW-1:0];
        end
      end
      default: begin
        vld_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p1: registered word, strobe, error flag and hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld_p1  <= '0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= vld_nxt;
      err_p1 <= err_nxt;
      cnt_p1 <= cnt_nxt;
      if (load) data_p1 <= in_data;
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign err_pulse = err_p1;

`ifdef DEMUX_ROUTE_ERRCNT_EN
  logic [7:0] errcnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      errcnt_p1 <= '0;
    end else if (err_nxt && (errcnt_p1 != 8'hFF)) begin
      errcnt_p1 <= errcnt_p1 + 8'd1;
    end
  end

  assign err_count = errcnt_p1;
`endif

endmodule

// File: doc/demux_route_18.md
DEMUX_ROUTE_18 -- requirements
Module: demux_route_18

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning the routed data width.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to hold a word while waiting for ack; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, DATA_W bits: the word to route.
REQ-006 SHALL have port in_ctrl, input, 4 bits: destination code; legal codes are 0000, 0001, 0010, 0011, 0100 and 1000.
REQ-007 SHALL have port in_valid, input, 1 bit: the source offers in_data and in_ctrl.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 SHALL have port out_data, output, DATA_W bits: the held word, shared by all destinations.
REQ-010 SHALL have port out_valid, output, 6 bits: one-hot destination strobe; bits 0..5 = codes 0000, 0001, 0010, 0011, 0100, 1000.
REQ-011 SHALL have port out_ack, input, 6 bits: per-destination acceptance.
REQ-012 SHALL have port err_pulse, output, 1 bit: a one-cycle flag for an illegal code or a timeout.

Function
REQ-013 SHALL implement two states, IDLE and HOLD; in_ready SHALL be 1 only in IDLE and not in reset.
REQ-014 SHALL accept a word when in_valid && in_ready; with a legal code it SHALL register out_data and set the matching out_valid bit at the next edge (latency 1), entering HOLD.
REQ-015 SHALL, for an illegal code, drop the word, stay in IDLE, keep out_valid at 0, and pulse err_pulse for exactly 1 cycle at the next edge.
REQ-016 SHALL, in HOLD, keep out_data and out_valid stable until out_ack has the bit set that matches the asserted out_valid bit.
REQ-017 SHALL, on a matching ack at edge M, clear out_valid and return to IDLE at M+1; in_ready SHALL be 1 in that cycle. There are no back-to-back accepts: throughput is at most 1 word per 2 cycles.
REQ-018 SHALL ignore out_ack bits for non-selected destinations, and all out_ack bits while in IDLE.
REQ-019 SHALL count HOLD cycles with a $clog2(TIMEOUT+1)-bit counter; when the counter reaches TIMEOUT without an ack, it SHALL clear out_valid, pulse err_pulse, and return to IDLE.
REQ-020 SHALL give precedence to the ack when the ack and timeout expiry coincide: no err_pulse.
REQ-021 SHALL retain the last out_data value in IDLE; only out_valid qualifies out_data.

Reset
REQ-022 SHALL, while rst=1 at an edge, force state=IDLE, out_valid=0, out_data=0, err_pulse=0 and timeout counter=0; in_ready SHALL be 0 while rst=1.
REQ-023 SHALL discard any held word when reset is asserted mid-HOLD, with no err_pulse.

Configuration
REQ-024 SHALL, when DEMUX_ROUTE_ERRCNT_EN is defined, add an output err_count, 8 bits, that increments on every err_pulse, saturates at 255, and resets to 0.
REQ-025 SHALL, when DEMUX_ROUTE_ERRCNT_EN is undefined, have no err_count port and no counter logic; all other behaviour is identical.

Structure
REQ-026 SHALL take the code constants CODE_0000..CODE_1000, the state enum, and the channel count 6 from shared package musa_route_pkg.
REQ-027 SHALL instantiate sub-module route_code_dec, which is purely combinational: in_ctrl -> 6-bit one-hot plus a legal flag.

Verification
REQ-028 SHALL verify this accept-and-ack sequence: in_ctrl=0011, in_data=18'h2A5A5, in_valid=1 at cycle 1 -> out_valid=6'b001000 and out_data=18'h2A5A5 at cycle 2; out_ack=6'b001000 at cycle 4 -> out_valid=0 and in_ready=1 at cycle 5.
REQ-029 SHALL verify this illegal-code case: in_ctrl=0101, in_valid=1 -> err_pulse=1 for 1 cycle, out_valid stays 0, in_ready stays 1, and err_count=1 if enabled.
REQ-030 SHALL verify this wrong-ack case: HOLD on code 1000, out_ack=6'b000001 -> out_valid=6'b100000 unchanged; after 15 HOLD cycles err_pulse=1 and out_valid=0.
REQ-031 SHALL verify that an ack arriving in the same cycle the counter reaches 15 -> clean release with err_pulse=0.
REQ-032 SHALL verify reset mid-HOLD: rst=1 for 1 cycle during HOLD on code 0100 -> next cycle out_valid=0, out_data=0, in_ready=0 during rst, in_ready=1 the following cycle.
REQ-033 SHALL verify saturation: 300 illegal codes with DEMUX_ROUTE_ERRCNT_EN defined -> err_count=255.
